power_detect: RTL
=================

# power_detect

Consumes the integrated power stream (32-bit unsigned power word plus strobe) produced by the power integrator and turns it into signal-presence events. A hysteresis state machine with programmable qualify/release counts raises a detect level and emits start/end strobes. Each completed event returns an end record of peak power and duration. It sits directly downstream of the integrator in the DSP chain and is programmed over the same settings bus.

## Interface
- BASE, 0, settings-bus base address; occupies BASE+0..BASE+3
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  synchronous; 0 forces IDLE and clears event state
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- power_in  in  32  unsigned integrated power sample
- strobe_in  in  1  power_in valid for this cycle; no backpressure
- detect  out  1  high while an event is declared (ACTIVE or RELEASE)
- start_stb  out  1  one-cycle pulse when an event is declared
- end_stb  out  1  one-cycle pulse when an event completes; qualifies peak_out and duration_out
- peak_out  out  32  maximum power_in seen during the event
- duration_out  out  32  strobes in the event, saturating
- event_count  out  16  completed events since reset or run rise; wraps 0xFFFF->0
- debug  out  32  {state[2:0], qual_cnt[15:0], 13'b0}

## Operation
- Registers are local with asynchronous reset to 0. They are written when set_stb is high and set_addr matches.
  - BASE+0: thresh_hi[31:0].
  - BASE+1: thresh_lo[31:0].
  - BASE+2: on_count[15:0] and off_count[31:16]. A value of 0 is treated as 1.
  - BASE+3: enable[0].
- A written value takes effect at the next strobe_in after the write cycle.
- Comparisons are unsigned. "hi" means power_in >= thresh_hi; "lo" means power_in < thresh_lo.
  - The thresholds are not required to be ordered.
  - If thresh_lo > thresh_hi, a single sample can satisfy both; the current state decides which test applies.
- States: IDLE, SEARCH, QUALIFY, ACTIVE, RELEASE.
- IDLE: entered when run=0 or enable=0, checked in every state. Clears qual_cnt, peak and duration. Exits to SEARCH when run=1 and enable=1.
- SEARCH, on strobe with hi:
  - Set peak=power_in, duration=1, qual_cnt=1.
  - If on_count==1, go to ACTIVE and pulse start_stb; otherwise go to QUALIFY.
- QUALIFY, on strobe:
  - duration++ and peak=max(peak, power_in).
  - If hi, qual_cnt++. When qual_cnt+1 == on_count, go to ACTIVE and pulse start_stb.
  - If not hi, go to SEARCH; no outputs change.
- ACTIVE, on strobe: duration++ and peak=max.
  - If lo: qual_cnt=1. If off_count==1, complete the event; otherwise go to RELEASE.
- RELEASE, on strobe: duration++ and peak=max.
  - If lo: qual_cnt++. When qual_cnt+1 == off_count, complete the event.
  - If not lo: return to ACTIVE with qual_cnt=0.
- Completing an event:
  - Pulse end_stb.
  - Load peak_out and duration_out with values that include the completing strobe.
  - event_count++.
  - Go to SEARCH.
- duration saturates at 0xFFFFFFFF. peak_out and duration_out hold between end_stb pulses.
- run or enable falling mid-event: go to IDLE and drop detect. No end_stb is issued and event_count is unchanged. A run rising edge clears event_count.

## Timing
- Reset values: every output is 0, state=IDLE, and all settings are 0.
- Latency: start_stb, end_stb, detect and the record outputs all update on the clock edge after the sampling strobe_in cycle, i.e. one cycle of latency.
- start_stb and end_stb are single-cycle. They never coincide, because start and end need separate strobes.
- detect rises in the same cycle as start_stb. detect falls in the same cycle as end_stb.
- Back-to-back strobes (strobe_in high every cycle) are fully supported. Throughput is one sample per clock.
- A settings write coincident with strobe_in: that strobe uses the old value.
- reset_n assertion mid-event clears everything immediately. Deassertion is synchronized by the reset generator outside this block.

## Test plan
- Configure thresh_hi=1000, thresh_lo=500, on=3, off=2, enable=1, run=1. Feed powers 1200, 1500, 1100, 800, 400, 300.
  - start_stb one cycle after the 1100 strobe.
  - end_stb one cycle after the 300 strobe, with peak_out=1500, duration_out=6 and event_count=1.
- Qualify abort: same config, feed 1200, 1200, 900, 1200.
  - No start_stb and detect stays 0.
  - The state is QUALIFY after the last sample (debug qual_cnt=1).
- Release abort: in an active event, feed 400, 700, 400, 400.
  - A single end_stb after the fourth sample.
  - duration_out counts all samples from the first 1200.
- Degenerate counts: on=0, off=0 (both treated as 1). Feed 2000, 100.
  - start_stb after the first sample.
  - end_stb after the second, with duration_out=2 and peak_out=2000.
- Abort: drop run to 0 during ACTIVE.
  - detect falls one cycle later.
  - No end_stb; event_count is reset on the next run rise.
  - Asserting reset_n=0 mid-event zeroes all outputs asynchronously.
- Stress: continuous strobe_in with random power and random register writes, checked against a reference model.
  - duration saturates at 0xFFFFFFFF.
  - event_count wraps after 65536 events.

Source files
------------

// File: rtl/power_detect.sv
// Signal-presence detector: hysteresis FSM over the integrated power stream,
// emitting start/end strobes and a per-event peak/duration record.
module power_detect #(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] power_in,
    input  logic        strobe_in,
    output logic        detect,
    output logic        start_stb,
    output logic        end_stb,
    output logic [31:0] peak_out,
    output logic [31:0] duration_out,
    output logic [15:0] event_count,
    output logic [31:0] debug
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEARCH  = 3'd1,
        S_QUALIFY = 3'd2,
        S_ACTIVE  = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    // Settings registers
    logic [31:0] thresh_hi_q, thresh_lo_q;
    logic [15:0] on_cnt_q, off_cnt_q;
    logic        enable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_hi_q <= '0;
            thresh_lo_q <= '0;
            on_cnt_q    <= '0;
            off_cnt_q   <= '0;
            enable_q    <= 1'b0;
        end else if (set_stb) begin
            if (set_addr == BASE)         thresh_hi_q <= set_data;
            if (set_addr == BASE + 8'd1)  thresh_lo_q <= set_data;
            if (set_addr == BASE + 8'd2) begin
                on_cnt_q  <= set_data[15:0];
                off_cnt_q <= set_data[31:16];
            end
            if (set_addr == BASE + 8'd3)  enable_q <= set_data[0];
        end
    end

    state_t      state_q, state_d;
    logic [15:0] qual_q, qual_d;
    logic [31:0] peak_q, peak_d;
    logic [31:0] dur_q, dur_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
    logic [31:0] peak_out_q, peak_out_d;
    logic [31:0] dur_out_q, dur_out_d;
    logic [15:0] evt_q, evt_d;
    logic        run_q;

    logic [15:0] on_eff, off_eff;
    logic [16:0] qual_inc;
    logic        hi, lo, go_idle, run_rise;
    logic        on_hit, off_hit, start_evt, end_evt;
    logic [31:0] peak_max, dur_inc;

    assign on_eff   = (on_cnt_q  == 16'd0) ? 16'd1 : on_cnt_q;
    assign off_eff  = (off_cnt_q == 16'd0) ? 16'd1 : off_cnt_q;
    assign hi       = power_in >= thresh_hi_q;
    assign lo       = power_in <  thresh_lo_q;
    assign go_idle  = !run || !enable_q;
    assign run_rise = run && !run_q;
    // 17-bit increment so a wrapped counter never falsely matches
    assign qual_inc = {1'b0, qual_q} + 17'd1;
    assign on_hit   = qual_inc == {1'b0, on_eff};
    assign off_hit  = qual_inc == {1'b0, off_eff};
    assign peak_max = (power_in > peak_q) ? power_in : peak_q;
    assign dur_inc  = (&dur_q) ? dur_q : dur_q + 32'd1;

    assign start_evt = !go_idle && strobe_in && hi &&
                       ((state_q == S_SEARCH  && on_eff == 16'd1) ||
                        (state_q == S_QUALIFY && on_hit));
    assign end_evt   = !go_idle && strobe_in && lo &&
                       ((state_q == S_ACTIVE  && off_eff == 16'd1) ||
                        (state_q == S_RELEASE && off_hit));

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            qual_q     <= '0;
            peak_q     <= '0;
            dur_q      <= '0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            peak_out_q <= '0;
            dur_out_q  <= '0;
            evt_q      <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            qual_q     <= qual_d;
            peak_q     <= peak_d;
            dur_q      <= dur_d;
            start_q    <= start_d;
            end_q      <= end_d;
            peak_out_q <= peak_out_d;
            dur_out_q  <= dur_out_d;
            evt_q      <= evt_d;
            run_q      <= run;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (go_idle) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_SEARCH;
                S_SEARCH:  if (strobe_in && hi)
                               state_d = start_evt ? S_ACTIVE : S_QUALIFY;
                S_QUALIFY: if (strobe_in)
                               state_d = !hi ? S_SEARCH : (start_evt ? S_ACTIVE : S_QUALIFY);
                S_ACTIVE:  if (strobe_in && lo)
                               state_d = end_evt ? S_SEARCH : S_RELEASE;
                S_RELEASE: if (strobe_in)
                               state_d = !lo ? S_ACTIVE : (end_evt ? S_SEARCH : S_RELEASE);
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        qual_d     = qual_q;
        peak_d     = peak_q;
        dur_d      = dur_q;
        peak_out_d = peak_out_q;
        dur_out_d  = dur_out_q;
        evt_d      = evt_q;
        start_d    = start_evt;
        end_d      = end_evt;
        if (run_rise) evt_d = '0;
        if (go_idle) begin
            qual_d = '0;
            peak_d = '0;
            dur_d  = '0;
        end else if (strobe_in) begin
            case (state_q)
                S_SEARCH: if (hi) begin
                    peak_d = power_in;
                    dur_d  = 32'd1;
                    qual_d = 16'd1;
                end
                S_QUALIFY: begin
                    peak_d = peak_max;
                    dur_d  = dur_inc;
                    if (hi) qual_d = qual_inc[15:0];
                end
                S_ACTIVE: begin
                    peak_d = peak_max;
                    dur_d  = dur_inc;
                    if (lo) qual_d = 16'd1;
                end
                S_RELEASE: begin
                    peak_d = peak_max;
                    dur_d  = dur_inc;
                    qual_d = lo ? qual_inc[15:0] : 16'd0;
                end
                default: ;
            endcase
        end
        // Record includes the completing strobe
        if (end_evt) begin
            peak_out_d = peak_max;
            dur_out_d  = dur_inc;
            evt_d      = evt_q + 16'd1;
        end
    end

    assign detect       = (state_q == S_ACTIVE) || (state_q == S_RELEASE);
    assign start_stb    = start_q;
    assign end_stb      = end_q;
    assign peak_out     = peak_out_q;
    assign duration_out = dur_out_q;
    assign event_count  = evt_q;
    assign debug        = {state_q, qual_q, 13'b0};

endmodule
